// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
        // Shifted partial remainder needs one extra bit before the trial subtract.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        o_acc    = i_acc;
        if (i_div) begin
            if (!w_diff[WIDTH])
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            else
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else begin
            if (i_acc[0])
                o_acc = {w_sum, i_acc[WIDTH-1:1]};
            else
                o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_t        dbg_state
);

    md_state_t          r_state;
    logic [5:0]         r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_div),
        .o_acc  (w_step)
    );

    always_comb begin
        w_signed   = (op == MD_OP_MULT) || (op == MD_OP_DIV);
        w_is_div   = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
        w_a_neg    = w_signed & a[WIDTH-1];
        w_b_neg    = w_signed & b[WIDTH-1];
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
        w_prod_neg = -r_acc;
        // Quotient sign is the XOR of operand signs; remainder follows the dividend.
        if (r_div) begin
            w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else begin
            w_fix_hi = r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_q ? w_prod_neg[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MD_OP_MTHI: r_hi <= a;
                            MD_OP_MTLO: r_lo <= a;
                            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                                r_div  <= w_is_div;
                                r_busy <= 1'b1;
                                r_cnt  <= '0;
                                if (w_is_div && (b == '0)) begin
                                    // Divide by zero: preload the fixed result and skip the iterations.
                                    r_acc   <= {a, {WIDTH{1'b1}}};
                                    r_neg_q <= 1'b0;
                                    r_neg_r <= 1'b0;
                                    r_state <= MD_ST_FIX;
                                end else begin
                                    r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                                    r_opnd  <= w_b_mag;
                                    r_neg_q <= w_a_neg ^ w_b_neg;
                                    r_neg_r <= w_a_neg;
                                    r_state <= MD_ST_CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MD_ST_CALC: begin
                    if (flush) begin
                        r_state <= MD_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(WIDTH - 1))
                            r_state <= MD_ST_FIX;
                    end
                end
                MD_ST_FIX: begin
                    r_state <= MD_ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= MD_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: latency, signed/unsigned results, divide by zero, MTxx, flush and reset.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_t   dbg_state;

    int n_checks;
    int n_fail;

    muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents the op for one edge, then counts cycles busy is seen high.
    task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int n_busy);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start  = 1'b0;
        n_busy = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            @(negedge clk);
        end
    endtask

    task automatic run_calc(input string tag, input logic [2:0] o, input logic [31:0] va,
                            input logic [31:0] vb, input int exp_lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        do_op(o, va, vb, n);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " result"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int n;
        bit saw_done;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = MD_OP_MULT;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset state", 64'(dbg_state), 64'(MD_ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        run_calc("multu max", MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("done one pulse", 64'(done), 64'd0);
        run_calc("mult -3*7", MD_OP_MULT, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_calc("mult min*min", MD_OP_MULT, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run_calc("div -7/2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_calc("div 7/-2", MD_OP_DIV, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
        run_calc("div -7/-2", MD_OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 32'hFFFFFFFF, 32'h00000003);
        run_calc("div min/-1", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
        run_calc("divu 1000/33", MD_OP_DIVU, 32'd1000, 32'd33, 33, 32'd10, 32'd30);
        run_calc("divu 100/0", MD_OP_DIVU, 32'd100, 32'd0, 1, 32'h00000064, 32'hFFFFFFFF);
        run_calc("div -5/0", MD_OP_DIV, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);

        do_op(MD_OP_MTHI, 32'h1234, 32'd0, n);
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi busy/done", {62'd0, busy, done}, 64'd0);
        do_op(MD_OP_MTLO, 32'h5678, 32'd0, n);
        check("mtlo lo", {hi, lo}, {32'h1234, 32'h5678});

        // start and flush together in IDLE: nothing accepted
        flush = 1'b1;
        do_op(MD_OP_MTLO, 32'hABCD, 32'd0, n);
        flush = 1'b0;
        check("flush beats start", {hi, lo}, {32'h1234, 32'h5678});
        flush = 1'b1;
        do_op(MD_OP_DIVU, 32'd50, 32'd7, n);
        flush = 1'b0;
        check("flush beats start busy", 64'(busy), 64'd0);

        // flush mid-CALC
        start = 1'b1; op = MD_OP_DIVU; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi/lo", {hi, lo}, {32'h1234, 32'h5678});
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("flush no done", 64'(saw_done), 64'd0);

        // start while busy is ignored
        start = 1'b1; op = MD_OP_DIVU; a = 32'd50; b = 32'd7;
        @(negedge clk);
        op = MD_OP_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        check("start while busy hi", 64'(hi), 64'h1234);
        n = 1;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy-start latency", 64'(n), 64'd33);
        check("busy-start result", {hi, lo}, {32'd1, 32'd7});

        // asynchronous reset mid-CALC
        start = 1'b1; op = MD_OP_DIVU; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset hi/lo", {hi, lo}, 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset state", 64'(dbg_state), 64'(MD_ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_calc("after reset multu", MD_OP_MULTU, 32'd12345, 32'd1000, 33, 32'd0, 32'd12345000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
